// File: rtl/conv_param_loader.sv
// Parameter loader: takes weight/threshold words on a valid/ready port and shifts them
// MSB-first onto single-bit load ports, committing each segment per fold.
module conv_param_loader #(
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned W_BITS   = 576,
   parameter int unsigned TH_BITS  = 10,
   parameter int unsigned FOLD     = 1,
   parameter int unsigned FOLD_LOG = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                stream_w_singlebit,
   output logic                stream_w_singlebit_en,
   output logic                stream_w_en,
   output logic [FOLD_LOG-1:0] stream_w_addr,
   output logic                stream_th_singlebit,
   output logic                stream_th_singlebit_en,
   output logic                stream_th_en,
   output logic [FOLD_LOG-1:0] stream_th_addr
);

   localparam int unsigned BC_W = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      IDLE, W_SHIFT, W_COMMIT, TH_SHIFT, TH_COMMIT, DONE
   } state_t;

   state_t              state, state_nx;
   logic [FOLD_LOG-1:0] fold, fold_nx;
   logic [CNT_W-1:0]    rem, rem_nx;
   logic [CNT_W-1:0]    unbuf, unbuf_nx;
   logic [CNT_W-1:0]    take;
   logic [WORD_W-1:0]   word_buf, word_buf_nx;
   logic [BC_W-1:0]     buf_cnt, buf_cnt_nx;
   logic                shifting, emit, accept;

   // Handshake and output decode, all from registered state
   always_comb begin
      shifting = (state == W_SHIFT) || (state == TH_SHIFT);
      emit     = shifting && (buf_cnt != '0);
      // Refill while the final buffered bit leaves so the stream never bubbles
      in_ready = shifting && (unbuf != '0) &&
                 ((buf_cnt == '0) || ((buf_cnt == BC_W'(1)) && emit));
      accept   = in_valid && in_ready;
      take     = (unbuf > CNT_W'(WORD_W)) ? CNT_W'(WORD_W) : unbuf;

      stream_w_singlebit_en  = emit && (state == W_SHIFT);
      stream_w_singlebit     = stream_w_singlebit_en && word_buf[WORD_W-1];
      stream_th_singlebit_en = emit && (state == TH_SHIFT);
      stream_th_singlebit    = stream_th_singlebit_en && word_buf[WORD_W-1];

      stream_w_en    = (state == W_COMMIT);
      stream_w_addr  = stream_w_en ? fold : '0;
      stream_th_en   = (state == TH_COMMIT);
      stream_th_addr = stream_th_en ? fold : '0;

      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Next-state, counters and word buffer
   always_comb begin
      state_nx    = state;
      fold_nx     = fold;
      rem_nx      = rem;
      unbuf_nx    = unbuf;
      word_buf_nx = word_buf;
      buf_cnt_nx  = buf_cnt;

      if (emit) begin
         word_buf_nx = {word_buf[WORD_W-2:0], 1'b0};
         buf_cnt_nx  = buf_cnt - BC_W'(1);
         rem_nx      = rem - CNT_W'(1);
      end
      // A fresh word only ever lands when the buffer is (about to be) empty
      if (accept) begin
         word_buf_nx = in_data;
         buf_cnt_nx  = BC_W'(take);
         unbuf_nx    = unbuf - take;
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_nx   = W_SHIFT;
               fold_nx    = '0;
               rem_nx     = CNT_W'(W_BITS);
               unbuf_nx   = CNT_W'(W_BITS);
               buf_cnt_nx = '0;
            end
         end
         W_SHIFT: begin
            if (emit && (rem == CNT_W'(1))) state_nx = W_COMMIT;
         end
         W_COMMIT: begin
            state_nx = TH_SHIFT;
            rem_nx   = CNT_W'(TH_BITS);
            unbuf_nx = CNT_W'(TH_BITS);
         end
         TH_SHIFT: begin
            if (emit && (rem == CNT_W'(1))) state_nx = TH_COMMIT;
         end
         TH_COMMIT: begin
            if (fold == FOLD_LOG'(FOLD - 1)) begin
               state_nx = DONE;
            end else begin
               state_nx = W_SHIFT;
               fold_nx  = fold + FOLD_LOG'(1);
               rem_nx   = CNT_W'(W_BITS);
               unbuf_nx = CNT_W'(W_BITS);
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         fold     <= '0;
         rem      <= '0;
         unbuf    <= '0;
         word_buf <= '0;
         buf_cnt  <= '0;
      end else begin
         state    <= state_nx;
         fold     <= fold_nx;
         rem      <= rem_nx;
         unbuf    <= unbuf_nx;
         word_buf <= word_buf_nx;
         buf_cnt  <= buf_cnt_nx;
      end
   end

endmodule

// File: tb/tb_conv_param_loader.sv
// Scoreboard bench for conv_param_loader: two configurations, expected output events
// are queued when words are scheduled and popped as the DUTs emit them.
module tb_conv_param_loader;

   typedef logic [7:0] wq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   // DUT1: WORD_W=8, W_BITS=8, TH_BITS=4, FOLD=1
   logic       reset1, start1, valid1, ready1, busy1, done1;
   logic [7:0] data1;
   logic       w_sb1, w_sben1, w_en1, t_sb1, t_sben1, t_en1;
   logic [0:0] w_addr1, t_addr1;
   // DUT2: WORD_W=8, W_BITS=12, TH_BITS=4, FOLD=2
   logic       reset2, start2, valid2, ready2, busy2, done2;
   logic [7:0] data2;
   logic       w_sb2, w_sben2, w_en2, t_sb2, t_sben2, t_en2;
   logic [0:0] w_addr2, t_addr2;

   logic [10:0] outs1, outs2;
   assign outs1 = {busy1, done1, ready1, w_sb1, w_sben1, w_en1, w_addr1, t_sb1, t_sben1, t_en1, t_addr1};
   assign outs2 = {busy2, done2, ready2, w_sb2, w_sben2, w_en2, w_addr2, t_sb2, t_sben2, t_en2, t_addr2};

   conv_param_loader #(.WORD_W(8), .W_BITS(8), .TH_BITS(4), .FOLD(1), .FOLD_LOG(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .reset(reset1), .start(start1), .busy(busy1), .done(done1),
      .in_data(data1), .in_valid(valid1), .in_ready(ready1),
      .stream_w_singlebit(w_sb1), .stream_w_singlebit_en(w_sben1),
      .stream_w_en(w_en1), .stream_w_addr(w_addr1),
      .stream_th_singlebit(t_sb1), .stream_th_singlebit_en(t_sben1),
      .stream_th_en(t_en1), .stream_th_addr(t_addr1));

   conv_param_loader #(.WORD_W(8), .W_BITS(12), .TH_BITS(4), .FOLD(2), .FOLD_LOG(1), .CNT_W(16)) u_dut2 (
      .clk(clk), .reset(reset2), .start(start2), .busy(busy2), .done(done2),
      .in_data(data2), .in_valid(valid2), .in_ready(ready2),
      .stream_w_singlebit(w_sb2), .stream_w_singlebit_en(w_sben2),
      .stream_w_en(w_en2), .stream_w_addr(w_addr2),
      .stream_th_singlebit(t_sb2), .stream_th_singlebit_en(t_sben2),
      .stream_th_en(t_en2), .stream_th_addr(t_addr2));

   // Event codes: 0/1 weight bit, 2/3 threshold bit, 4+f weight commit, 6+f threshold commit, 8 done
   int   q1[$], q2[$];
   logic [7:0] dq1[$], dq2[$];
   int   gapq2[$];
   int   wcnt1 = 0, done1_cnt = 0, last2 = -1, wseg2 = 0;
   int   gap_at = 0, gap_left = 0;
   logic fall1 = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int ev_code(input logic wsb, input logic wsben, input logic wen, input logic waddr,
                                  input logic tsb, input logic tsben, input logic ten, input logic taddr,
                                  input logic dn);
      if (wsben) return int'(wsb);
      if (tsben) return 2 + int'(tsb);
      if (wen)   return 4 + int'(waddr);
      if (ten)   return 6 + int'(taddr);
      if (dn)    return 8;
      return -1;
   endfunction

   function automatic int bad_idle(input logic wsb, input logic wsben, input logic wen, input logic waddr,
                                   input logic tsb, input logic tsben, input logic ten, input logic taddr,
                                   input logic dn);
      int n;
      n = int'(wsben) + int'(tsben) + int'(wen) + int'(ten) + int'(dn);
      return int'((n > 1) || (!wsben && wsb) || (!tsben && tsb) || (!wen && waddr) || (!ten && taddr));
   endfunction

   task automatic push_ev(input int d, input int e);
      if (d == 1) q1.push_back(e); else q2.push_back(e);
   endtask

   // Reference model: segments start on fresh words, bits go MSB-first, leftovers dropped
   task automatic model_load(input int d, input int wb, input int tb, input int nf, input wq_t words);
      int wi, left;
      logic [7:0] w;
      wi = 0;
      for (int f = 0; f < nf; f++) begin
         for (int s = 0; s < 2; s++) begin
            left = (s == 0) ? wb : tb;
            while (left > 0) begin
               w = words[wi];
               wi++;
               if (d == 1) dq1.push_back(w); else dq2.push_back(w);
               for (int b = 7; b >= 0 && left > 0; b--) begin
                  push_ev(d, 2 * s + int'(w[b]));
                  left--;
               end
            end
            push_ev(d, 4 + 2 * s + f);
         end
      end
      push_ev(d, 8);
   endtask

   // Word drivers: acceptance sampled at the active edge, data updated on the falling edge
   always @(posedge clk) begin
      if (!reset1 && valid1 && ready1 && dq1.size() > 0) void'(dq1.pop_front());
      if (!reset2 && valid2 && ready2 && dq2.size() > 0) void'(dq2.pop_front());
   end

   always @(negedge clk) begin
      valid1 = (dq1.size() > 0);
      data1  = valid1 ? dq1[0] : 8'h00;
      valid2 = (dq2.size() > 0);
      data2  = valid2 ? dq2[0] : 8'h00;
      if (valid2 && gap_left > 0 && dq2.size() == gap_at) begin
         valid2 = 1'b0;
         if (ready2) gap_left--;
      end
   end

   always @(negedge clk) begin
      int c;
      if (!reset1) begin
         c = ev_code(w_sb1, w_sben1, w_en1, w_addr1[0], t_sb1, t_sben1, t_en1, t_addr1[0], done1);
         chk("idle_bits1", bad_idle(w_sb1, w_sben1, w_en1, w_addr1[0], t_sb1, t_sben1, t_en1, t_addr1[0], done1), 0);
         if (fall1) begin
            chk("busy_fall1", int'(busy1), 0);
            fall1 = 1'b0;
         end
         if (c >= 0) begin
            chk("busy1", int'(busy1), 1);
            if (q1.size() == 0) chk("extra_ev1", c, -1);
            else chk("ev1", c, q1.pop_front());
            if (c < 2) wcnt1++;
            if (c >= 4) wcnt1 = 0;
            if (c == 8) begin
               done1_cnt++;
               fall1 = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      int c;
      if (!reset2) begin
         c = ev_code(w_sb2, w_sben2, w_en2, w_addr2[0], t_sb2, t_sben2, t_en2, t_addr2[0], done2);
         chk("idle_bits2", bad_idle(w_sb2, w_sben2, w_en2, w_addr2[0], t_sb2, t_sben2, t_en2, t_addr2[0], done2), 0);
         if (c >= 0) begin
            chk("busy2", int'(busy2), 1);
            if (q2.size() == 0) chk("extra_ev2", c, -1);
            else chk("ev2", c, q2.pop_front());
            if (c < 4) begin
               if (last2 >= 0 && cyc - last2 - 1 != 0) gapq2.push_back(cyc - last2 - 1);
               last2 = cyc;
            end
            if (c < 2) begin
               wseg2++;
               if (wseg2 == 8) chk("ready_last_bit", int'(ready2), 1);
            end
            if (c >= 4) begin
               last2 = -1;
               wseg2 = 0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input int d, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (d == 1 && q1.size() == 0 && !busy1) break;
         if (d == 2 && q2.size() == 0 && !busy2) break;
      end
      if (d == 1) chk("drain1", q1.size(), 0);
      else chk("drain2", q2.size(), 0);
   endtask

   initial begin
      wq_t w;
      int  d0;
      reset1 = 1'b1; reset2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
      repeat (3) tick();
      chk("reset_outs1", int'(outs1), 0);
      chk("reset_outs2", int'(outs2), 0);
      reset1 = 1'b0; reset2 = 1'b0;
      tick();
      chk("idle_outs1", int'(outs1), 0);
      chk("idle_outs2", int'(outs2), 0);

      // Basic load with a stray start pulse while busy
      d0 = done1_cnt;
      w = {8'hA5, 8'hC3};
      model_load(1, 8, 4, 1, w);
      start1 = 1'b1; tick(); start1 = 1'b0;
      repeat (5) tick();
      start1 = 1'b1; tick(); start1 = 1'b0;
      wait_idle(1, 200);
      repeat (6) tick();
      chk("single_done", done1_cnt - d0, 1);

      // Two folds, words back to back
      w = {8'hFF, 8'h0F, 8'h90, 8'h00, 8'h30, 8'h60};
      model_load(2, 12, 4, 2, w);
      start2 = 1'b1; tick(); start2 = 1'b0;
      wait_idle(2, 300);
      chk("no_gaps", gapq2.size(), 0);
      gapq2.delete();

      // Same load with in_valid withheld for 5 ready cycles before the second fold-1 word
      gap_at = 2; gap_left = 5;
      model_load(2, 12, 4, 2, w);
      start2 = 1'b1; tick(); start2 = 1'b0;
      wait_idle(2, 300);
      chk("gap_count", gapq2.size(), 1);
      chk("gap_len", (gapq2.size() > 0) ? gapq2[0] : -1, 5);
      gapq2.delete();

      // start held high: exactly two back-to-back loads
      d0 = done1_cnt;
      w = {8'hA5, 8'hC3};
      model_load(1, 8, 4, 1, w);
      w = {8'h3C, 8'h5A};
      model_load(1, 8, 4, 1, w);
      start1 = 1'b1;
      for (int i = 0; i < 200 && done1_cnt == d0; i++) tick();
      chk("first_held_done", done1_cnt - d0, 1);
      tick(); tick();
      start1 = 1'b0;
      wait_idle(1, 200);
      repeat (6) tick();
      chk("held_dones", done1_cnt - d0, 2);

      // Reset after three weight bits, then a clean reload
      w = {8'hA5, 8'hC3};
      model_load(1, 8, 4, 1, w);
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int i = 0; i < 100 && wcnt1 < 3; i++) tick();
      chk("bits_before_reset", wcnt1, 3);
      reset1 = 1'b1;
      q1.delete(); dq1.delete();
      wcnt1 = 0; fall1 = 1'b0;
      tick();
      reset1 = 1'b0;
      chk("mid_reset_outs", int'(outs1), 0);
      repeat (4) tick();
      chk("post_reset_quiet", int'(outs1), 0);
      d0 = done1_cnt;
      w = {8'h5A, 8'h96};
      model_load(1, 8, 4, 1, w);
      start1 = 1'b1; tick(); start1 = 1'b0;
      wait_idle(1, 200);
      chk("reload_done", done1_cnt - d0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
